// File: rtl/rv_pkg.sv
// Shared definitions for the fetch slice: default address width, instruction
// width and the fetch-controller state encoding.
package rv_pkg;
    localparam int ADDR_W_DEFAULT = 32;
    localparam int INSTR_W        = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear; used for both
// the in-flight PC tag queue and the decoded-instruction output queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_din,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_dout,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Overflow/underflow attempts are dropped rather than corrupting pointers.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues aligned PCs to imem under credit control, pairs
// in-order responses with their PCs and queues them for decode; handles flush.
module instr_fetch
    import rv_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic                pc_valid,
    output logic                pc_ready,
    output logic                req_valid,
    output logic [ADDR_W-1:0]   req_addr,
    input  logic                req_ready,
    input  logic                resp_valid,
    input  logic [INSTR_W-1:0]  resp_data,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    input  logic                flush,
    output logic                misalign_err
);
    localparam int OCW = $clog2(MAX_OUT) + 1;
    localparam int QCW = $clog2(FIFO_DEPTH) + 1;
    localparam int QW  = ADDR_W + INSTR_W;

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [OCW-1:0]   r_outstanding;
    logic [OCW-1:0]   w_outstanding_next;
    logic [OCW-1:0]   r_drop_cnt;
    logic [OCW-1:0]   w_drop_next;
    logic [OCW-1:0]   w_inflight_after;
    logic             r_misalign;

    logic             w_misaligned;
    logic             w_credit_ok;
    logic             w_accept;
    logic             w_resp;
    logic             w_resp_drop;
    logic             w_resp_keep;
    logic             w_deq;

    logic [ADDR_W-1:0] w_tag_pc;
    logic              w_tag_empty;
    logic              w_tag_full;
    logic [OCW-1:0]    w_tag_count;
    logic [QW-1:0]     w_q_head;
    logic              w_q_empty;
    logic              w_q_full;
    logic [QCW-1:0]    w_q_count;
    logic              w_unused;

    assign w_misaligned = (pc_in[1:0] != 2'b00);

    // Same-cycle decode pops are deliberately not credited.
    assign w_credit_ok = (int'(r_outstanding) < MAX_OUT)
                      && (int'(r_outstanding) + int'(w_q_count) < FIFO_DEPTH)
                      && !w_tag_full;

    assign w_accept = rst && (r_state == ST_RUN) && pc_valid && req_ready
                   && !flush && !w_misaligned && w_credit_ok;

    assign pc_ready  = w_accept;
    assign req_valid = w_accept;
    assign req_addr  = pc_in;

    // Responses with nothing outstanding (e.g. pre-reset requests) are ignored.
    assign w_resp      = resp_valid && (r_outstanding != '0);
    assign w_resp_drop = w_resp && (r_drop_cnt != '0);
    assign w_resp_keep = w_resp && (r_drop_cnt == '0) && !flush && !w_tag_empty;

    assign w_inflight_after   = r_outstanding - OCW'(w_resp);
    assign w_outstanding_next = r_outstanding + OCW'(w_accept) - OCW'(w_resp);

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop_cnt - OCW'(w_resp_drop);
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_drop_next  = w_inflight_after;
                    w_state_next = (w_inflight_after != '0) ? ST_DRAIN : ST_RUN;
                end else if (pc_valid && w_misaligned) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_DRAIN: begin
                if (w_drop_next == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_ERR: begin
                if (flush) begin
                    w_drop_next  = w_inflight_after;
                    w_state_next = (w_inflight_after != '0) ? ST_DRAIN : ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_next;
            r_misalign    <= (w_state_next == ST_ERR);
        end
    end

    assign misalign_err = r_misalign;

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUT)
    ) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_push  (w_accept),
        .i_din   (pc_in),
        .i_pop   (w_resp_keep),
        .o_dout  (w_tag_pc),
        .o_empty (w_tag_empty),
        .o_full  (w_tag_full),
        .o_count (w_tag_count)
    );

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_q (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_push  (w_resp_keep),
        .i_din   ({w_tag_pc, resp_data}),
        .i_pop   (w_deq),
        .o_dout  (w_q_head),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_count (w_q_count)
    );

    assign instr_valid = !w_q_empty;
    assign w_deq       = instr_valid && instr_ready;
    assign instr       = instr_valid ? w_q_head[INSTR_W-1:0] : '0;
    assign instr_pc    = instr_valid ? w_q_head[QW-1:INSTR_W] : '0;

    assign w_unused = ^{w_tag_count, w_q_full};
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: an in-order imem model feeds responses and a
// scoreboard queue holds the {pc, data} each accepted request should deliver.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        flush;
    logic        misalign_err;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] exp_q[$];
    logic [31:0] pend_q[$];
    bit          imem_auto;
    bit          last_fire;
    int          waits;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W     (32),
        .FIFO_DEPTH (2),
        .MAX_OUT    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .flush        (flush),
        .misalign_err (misalign_err)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1357;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, got, exp);
    endtask

    // One clock: check any decode pop against the scoreboard, record an issued
    // request, then at the falling edge present the next imem response.
    task automatic cycle();
        logic        fire;
        logic [63:0] e;
        logic [31:0] a;
        #1;
        fire = req_valid && req_ready;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                chk1("spurious_instr", instr_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk32("instr_pc", instr_pc, e[63:32]);
                chk32("instr_data", instr, e[31:0]);
                $display("deliver pc=%h instr=%h", instr_pc, instr);
            end
        end
        if (fire) begin
            pend_q.push_back(req_addr);
            exp_q.push_back({req_addr, imem_word(req_addr)});
            $display("request addr=%h", req_addr);
        end
        last_fire = fire;
        @(negedge clk);
        if (imem_auto && pend_q.size() > 0) begin
            a = pend_q.pop_front();
            resp_valid = 1'b1;
            resp_data  = imem_word(a);
        end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
    endtask

    task automatic send(input logic [31:0] a);
        pc_valid  = 1'b1;
        pc_in     = a;
        last_fire = 1'b0;
        for (int i = 0; i < 20 && !last_fire; i++) cycle();
        chk1("send_accepted", last_fire, 1'b1);
        pc_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) cycle();
        chk32("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        last_fire = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_fire) break;
            n++;
        end
        pc_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        rst = 1'b0; pc_in = '0; pc_valid = 1'b1; req_ready = 1'b1;
        resp_valid = 1'b0; resp_data = '0; instr_ready = 1'b0; flush = 1'b0;
        imem_auto = 1'b1; last_fire = 1'b0;
        #3;
        chk1("rst_pc_ready", pc_ready, 1'b0);
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk1("rst_misalign", misalign_err, 1'b0);
        chk32("rst_instr", instr, 32'd0);
        chk32("rst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1; pc_valid = 1'b0;

        // Streaming with latency-1 imem; first word visible one cycle after resp.
        send(32'h0);
        chk1("lat_before_resp", instr_valid, 1'b0);
        cycle();
        chk1("lat_after_resp", instr_valid, 1'b1);
        chk32("lat_pc", instr_pc, 32'h0);
        chk32("lat_data", instr, imem_word(32'h0));
        instr_ready = 1'b1;
        send(32'h4);
        send(32'h8);
        drain(20);

        // Backpressure: only FIFO_DEPTH requests go out while decode stalls.
        instr_ready = 1'b0;
        pc_valid = 1'b1; pc_in = 32'h100; fires = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_fire) begin
                fires++;
                pc_in = pc_in + 32'd4;
            end
        end
        #1;
        chk32("bp_issued", 32'(fires), 32'd2);
        chk1("bp_pc_ready_low", pc_ready, 1'b0);
        instr_ready = 1'b1;
        send(32'h108);
        drain(20);

        // Flush with two requests in flight: both responses are discarded.
        imem_auto = 1'b0;
        send(32'h200);
        send(32'h204);
        imem_auto = 1'b1;
        exp_q.delete();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk1("flush_misalign_clear", misalign_err, 1'b0);
        pc_valid = 1'b1; pc_in = 32'h40;
        wait_accept(waits);
        chk32("flush_drain_cycles", 32'(waits), 32'd2);
        drain(20);

        // Flush coinciding with a response: that response is not enqueued.
        imem_auto = 1'b0;
        send(32'h300);
        send(32'h304);
        imem_auto = 1'b1;
        cycle();
        exp_q.delete();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk1("flush_resp_not_enq", instr_valid, 1'b0);
        pc_valid = 1'b1; pc_in = 32'h80;
        wait_accept(waits);
        chk32("flush_resp_drain_cycles", 32'(waits), 32'd1);
        drain(20);

        // Misaligned PC: error flag, no requests, queued words still delivered.
        instr_ready = 1'b0;
        send(32'h500);
        send(32'h504);
        cycle();
        cycle();
        chk1("mis_queued", instr_valid, 1'b1);
        pc_valid = 1'b1; pc_in = 32'h6;
        #1;
        chk1("mis_req_valid_now", req_valid, 1'b0);
        cycle();
        chk1("mis_err_set", misalign_err, 1'b1);
        pc_in = 32'h10;
        #1;
        chk1("mis_err_no_req", req_valid, 1'b0);
        instr_ready = 1'b1;
        drain(10);
        chk1("mis_err_sticky", misalign_err, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk1("mis_err_cleared", misalign_err, 1'b0);
        #1;
        chk1("mis_recover_ready", pc_ready, 1'b1);
        send(32'h10);
        drain(20);

        // Asynchronous reset mid-stream with one request in flight.
        instr_ready = 1'b0;
        send(32'h5F0);
        cycle();
        chk1("ar_pre_valid", instr_valid, 1'b1);
        imem_auto = 1'b0;
        send(32'h600);
        pc_valid = 1'b1; pc_in = 32'h604;
        #2 rst = 1'b0;
        #1;
        chk1("ar_pc_ready", pc_ready, 1'b0);
        chk1("ar_req_valid", req_valid, 1'b0);
        chk1("ar_instr_valid", instr_valid, 1'b0);
        chk32("ar_instr", instr, 32'd0);
        chk32("ar_instr_pc", instr_pc, 32'd0);
        chk1("ar_misalign", misalign_err, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1; pc_valid = 1'b0; instr_ready = 1'b1; imem_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("ar_stale_ignored", instr_valid, 1'b0);
        end
        send(32'h700);
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC/address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning output instruction queue entries (power of 2).
REQ-003 SHALL have parameter MAX_OUT, default 2, meaning max in-flight imem requests (power of 2).
REQ-004 SHALL have ports: clk  in  1  the single clock; rst  in  1  asynchronous reset, active-low.
REQ-005 SHALL have ports: pc_in  in  ADDR_W  fetch address from PC_adder; pc_valid  in  1  pc_in valid; pc_ready  out  1  address accepted this cycle.
REQ-006 SHALL have ports: req_valid  out  1; req_addr  out  ADDR_W; req_ready  in  1, all to imem.
REQ-007 SHALL have ports: resp_valid  in  1; resp_data  in  32, from imem, in order, latency >= 1.
REQ-008 SHALL have ports: instr_valid  out  1; instr  out  32; instr_pc  out  ADDR_W; instr_ready  in  1, all to decode.
REQ-009 SHALL have ports: flush  in  1  branch redirect, discards all fetched/in-flight work; misalign_err  out  1  sticky misaligned-PC flag.

Function
REQ-010 SHALL accept an address (pc_ready=1) only when state=RUN, pc_valid=1, req_ready=1, flush=0, pc_in[1:0]=0, outstanding<MAX_OUT and outstanding+fifo_count<FIFO_DEPTH.
REQ-011 SHALL drive req_valid=pc_ready and req_addr=pc_in combinationally; handshake = req_valid&req_ready.
REQ-012 SHALL push each accepted pc_in into an internal tag queue (depth MAX_OUT) and increment outstanding.
REQ-013 SHALL, on resp_valid with drop_cnt=0, pop the tag queue and write {tag PC, resp_data} into the output queue in the same edge; outstanding decrements.
REQ-014 SHALL, on resp_valid with drop_cnt>0, discard the response and decrement drop_cnt and outstanding.
REQ-015 SHALL ignore resp_valid when outstanding=0.
REQ-016 SHALL drive instr_valid=!empty, instr/instr_pc from queue head; pop on instr_valid&instr_ready; simultaneous push and pop permitted, count unchanged.
REQ-017 SHALL deliver an instruction to decode one cycle after its resp_valid (registered queue output).
REQ-018 SHALL implement FSM RUN/DRAIN/ERR: RUN->DRAIN on flush with in-flight responses remaining; RUN->ERR on pc_valid with pc_in[1:0]!=0; DRAIN->RUN when drop_cnt reaches 0; ERR->DRAIN/RUN on flush per in-flight count.
REQ-019 SHALL, on flush, empty output queue and tag queue, set drop_cnt=outstanding minus any response arriving that same cycle, clear misalign_err, and accept no address that cycle.
REQ-020 SHALL, in DRAIN, issue no requests; a flush during DRAIN leaves drop_cnt unchanged.
REQ-021 SHALL, in ERR, assert misalign_err, issue no requests, and continue draining the output queue to decode.
REQ-022 SHALL never overflow either queue; credit check in REQ-010 is conservative (same-cycle pops not credited).

Reset
REQ-023 SHALL, on rst=0 asynchronously, set state=RUN, outstanding=0, drop_cnt=0, queues empty, instr_valid=0, misalign_err=0, pc_ready=0, req_valid=0, instr=0, instr_pc=0.
REQ-024 SHALL treat responses arriving after reset release for pre-reset requests as ignored (outstanding=0).

Structure
REQ-025 SHALL place ADDR_W default, instruction width 32, and the FSM state encoding in shared package rv_pkg.
REQ-026 SHALL use one sub-module, fetch_fifo (synchronous FIFO, parameterised width/depth, count output), instantiated for tag queue and output queue.

Verification
REQ-027 SHALL test streaming: pc 0x0,0x4,0x8, imem latency 1, instr_ready=1 -> instr_pc 0x0,0x4,0x8 in order with matching resp_data, one per cycle after fill.
REQ-028 SHALL test backpressure: instr_ready=0, FIFO_DEPTH=2 -> exactly 2 requests issued, then pc_ready=0 until decode pops.
REQ-029 SHALL test flush with 2 in flight: flush at cycle N -> next 2 resp_valid discarded, DRAIN held, first post-flush pc (e.g. 0x40) emerges as instr_pc 0x40.
REQ-030 SHALL test misalignment: pc_in=0x6 -> misalign_err=1, req_valid=0, queued instructions still delivered; flush clears flag.
REQ-031 SHALL test async reset mid-stream: rst=0 with 1 in flight -> all outputs 0 immediately; stale resp_valid after release produces no instr_valid.
REQ-032 SHALL test simultaneous flush and resp_valid: drop_cnt = outstanding-1, response not enqueued.
